// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master.
package apb_arb_pkg;

  localparam int unsigned N_REQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick (combinational) with a registered priority pointer.
module rr_arb2
  import apb_arb_pkg::*;
(
  input  logic             pclk,
  input  logic             rst,
  input  logic [N_REQ-1:0] eligible,
  input  logic             grant_stb,
  output logic [N_REQ-1:0] grant_c,
  output logic             grant_idx_c
);

  logic ptr;

  // Pointer requester wins when eligible, otherwise the other one.
  always_comb begin
    grant_idx_c = ptr;
    grant_c     = '0;
    if (!eligible[ptr]) grant_idx_c = ~ptr;
    if (|eligible) grant_c[grant_idx_c] = 1'b1;
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (grant_stb && (|eligible)) begin
      ptr <= ~grant_idx_c;
    end
  end

endmodule

// File: rtl/apb_master_arb.sv
// Two-client APB master: round-robin arbitration, SETUP/ACCESS sequencing
// and a per-transfer pready timeout.
module apb_master_arb
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                    pclk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*ADDR_W-1:0] req_addr,
  input  logic [N_REQ-1:0]        req_write,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        req_done,
  output logic [DATA_W-1:0]       rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_W-1:0]       paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_W-1:0]       pwdata,
  input  logic                    pready,
  input  logic [DATA_W-1:0]       prdata
);

  localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t           state;
  logic             gnt_idx;
  logic [CNT_W-1:0] cnt;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] grant_c;
  logic             grant_idx_c;
  logic             timeout_hit_c;

  // The requester completed last cycle is masked so its held valid is not re-granted.
  assign eligible      = req_valid & ~req_done;
  assign timeout_hit_c = (TIMEOUT > 0) && (cnt == CNT_LAST);

  rr_arb2 u_rr_arb2 (
    .pclk        (pclk),
    .rst         (rst),
    .eligible    (eligible),
    .grant_stb   (state == ST_IDLE),
    .grant_c     (grant_c),
    .grant_idx_c (grant_idx_c)
  );

  always_ff @(posedge pclk) begin
    if (rst) begin
      state     <= ST_IDLE;
      gnt_idx   <= 1'b0;
      cnt       <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      req_done  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      req_done <= '0;
      case (state)
        ST_IDLE: begin
          if (|grant_c) begin
            paddr   <= grant_idx_c ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
            pwdata  <= grant_idx_c ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
            pwrite  <= req_write[grant_idx_c];
            gnt_idx <= grant_idx_c;
            psel    <= 1'b1;
            state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable <= 1'b1;
          cnt     <= '0;
          state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (pready || timeout_hit_c) begin
            psel     <= 1'b0;
            penable  <= 1'b0;
            req_done <= gnt_idx ? 2'b10 : 2'b01;
            rsp_err  <= ~pready;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
            state    <= ST_IDLE;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/apb_master_arb.md
# apb_master_arb

Two-requester APB master: accepts single-word read/write requests from two internal clients, arbitrates round-robin, and sequences each winner through APB SETUP/ACCESS phases on one shared bus. It sits between UART-side control clients (e.g. config engine, test sequencer) and the APB slave; its bus pins map one-to-one onto the master-side signals of `apb_if`. A per-transfer `pready` timeout keeps a dead slave from hanging the bus.

## Interface
- `ADDR_W`, 32, APB address width
- `DATA_W`, 32, APB data width
- `TIMEOUT`, 16, max ACCESS cycles waiting for `pready`; 0 disables the timeout
- `pclk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid`  in  2  per-requester request; held high with fields stable until its `req_done` pulse
- `req_addr`  in  2*ADDR_W  packed addresses, requester i at bits [i*ADDR_W +: ADDR_W]
- `req_write`  in  2  1 = write, 0 = read
- `req_wdata`  in  2*DATA_W  packed write data
- `req_done`  out  2  one-cycle completion pulse, one-hot
- `rsp_rdata`  out  DATA_W  read data, valid while `req_done` is nonzero
- `rsp_err`  out  1  timeout flag, valid while `req_done` is nonzero
- `paddr`  out  ADDR_W  APB address
- `psel`  out  1  APB select
- `penable`  out  1  APB enable
- `pwrite`  out  1  APB direction
- `pwdata`  out  DATA_W  APB write data
- `pready`  in  1  APB ready
- `prdata`  in  DATA_W  APB read data

## Operation
- All outputs are registered. Reset values: `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `req_done`=0, `rsp_rdata`=0, `rsp_err`=0. On reset the state is IDLE, the priority pointer is 0, and the timeout counter is 0.
- FSM states: IDLE, SETUP, ACCESS.
- **IDLE.** Eligible set = `req_valid & ~req_done`. The just-served requester is masked for this one cycle so that its held `valid` is not re-granted.
  - If the eligible set is nonzero, pick the winner round-robin: the pointer requester wins if eligible, otherwise the other one.
  - On a grant, latch `paddr`/`pwrite`/`pwdata` from the winner, store the grant index, set `psel`=1, and go to SETUP.
  - On every grant the pointer moves to the non-winner.
- **SETUP.** `psel`=1, `penable`=0 for exactly one cycle, then go to ACCESS with `penable`=1. Clear the counter.
- **ACCESS.** `psel`=1 and `penable`=1. Each cycle samples `pready`.
  - `pready`=1: go to IDLE. Drop `psel`/`penable`. Pulse `req_done[grant]`, `rsp_err`=0. `rsp_rdata` = `prdata` on reads, 0 on writes.
  - `pready`=0 and counter = `TIMEOUT`-1 (with `TIMEOUT`>0): go to IDLE. Drop `psel`/`penable`. Pulse `req_done[grant]`, `rsp_err`=1, `rsp_rdata`=0.
  - Otherwise increment the counter. The counter is `$clog2(TIMEOUT+1)` bits wide and never wraps.
- `paddr`/`pwrite`/`pwdata` stay stable from SETUP through the last ACCESS cycle. After completion they hold their last value; they are not cleared.
- A requester dropping `req_valid` mid-transfer has no effect; the transfer completes and `req_done` still pulses.
- `rst` asserted in any state aborts immediately to reset values next edge. No `req_done` is issued for the aborted transfer.

## Timing
- Request sampled in IDLE at edge N:
  - SETUP visible after N.
  - ACCESS after N+1.
  - With zero wait states (`pready`=1 at edge N+2), `req_done` is high after edge N+2 and `psel`=0 in the same cycle.
- Each wait state adds one cycle. Minimum bus occupancy is 3 cycles per transfer (IDLE, SETUP, ACCESS), so peak throughput is one transfer per 3 cycles.
- A timeout completes after exactly `TIMEOUT` ACCESS cycles.
- `rsp_rdata` and `rsp_err` are meaningful only in `req_done` cycles. `rsp_rdata` holds its value otherwise.

## Structure
- Package `apb_arb_pkg` holds:
  - the state enum (`ST_IDLE`, `ST_SETUP`, `ST_ACCESS`);
  - the constant `N_REQ`=2.
- Sub-module `rr_arb2` is the combinational 2-way round-robin pick plus the registered pointer. Inputs: eligible set and grant-strobe. Outputs: one-hot grant and index.
- The top level holds the FSM, address/data latches, timeout counter and response registers.

## Test plan
- **Single write, no wait.** Requester 0 writes addr 0x10, data 0xA5A5_0001, `pready` tied 1 → `psel` for 2 cycles, `penable` for 1, `req_done`=2'b01 3 cycles after `req_valid` is sampled, `rsp_err`=0.
- **Read with wait states.** Requester 1 reads addr 0x04, `pready` low for 3 ACCESS cycles, `prdata`=0x0000_00C3 → ACCESS lasts 4 cycles, `req_done`=2'b10, `rsp_rdata`=0xC3.
- **Round-robin contention.** Both requesters valid continuously for 4 transfers → grant order 0,1,0,1. The bus is never idle more than 1 cycle between transfers. No requester is served twice in a row.
- **Timeout.** `TIMEOUT`=16, `pready` stuck 0 → `psel` drops after exactly 16 ACCESS cycles, `rsp_err`=1, `rsp_rdata`=0. The next request then proceeds normally.
- **Reset mid-ACCESS.** `rst` pulsed during a wait state → next cycle all outputs are 0, no `req_done`, and a new request from requester 0 wins first.
- **Stability check.** An assertion holds `paddr`/`pwrite`/`pwdata` constant while `psel`=1 and enforces that `penable` rises only one cycle after `psel` rises. It runs across 200 random mixed transfers with random `pready` delays of 0–5 cycles.
